// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional performance counters are enabled with FETCH_PERF_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 32;
  localparam int PERF_CNT_W  = 16;

  // Sticks at all-ones instead of wrapping
  function automatic logic [PERF_CNT_W-1:0] sat_add(input logic [PERF_CNT_W-1:0] a,
                                                    input logic [PERF_CNT_W-1:0] b);
    logic [PERF_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[PERF_CNT_W]) begin
      return {PERF_CNT_W{1'b1}};
    end else begin
      return sum[PERF_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head entry is read straight from storage (no bypass).
// A push into a full queue is accepted only when a pop frees a slot in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == {(AW+1){1'b0}});
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers, occupancy and storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests, prefetch queue, redirect/flush.
// Defining FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               done
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetched,
  output logic [PERF_CNT_W-1:0] perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          r_state;
  logic [PC_W-1:0]       r_pc;
  logic [CW-1:0]         r_discard;
  logic                  r_done;

  logic                  w_redir;
  logic                  w_issue;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit;
  logic [PC_W-1:0]       w_pc_next;
  logic [CW-1:0]         w_q_count;
  logic                  w_q_full;
  logic                  w_q_empty;
  logic [INSTR_W+PC_W-1:0] w_q_data;
  logic [CW-1:0]         w_inflight;
  logic                  w_sh_full;
  logic                  w_sh_empty;
  logic [PC_W-1:0]       w_sh_pc;

  assign w_redir   = redirect_valid && (r_state != IDLE);
  assign w_pc_next = r_pc + PC_W'(PC_STEP);
  assign w_credit  = ({1'b0, w_q_count} + {1'b0, w_inflight}) < (CW+1)'(DEPTH);
  assign imem_req  = (r_state == FETCH) && !redirect_valid && w_credit && !w_sh_full && !w_q_full;
  assign imem_addr = r_pc;
  assign w_issue   = imem_req && imem_gnt;
  // Any response arriving during a redirect or while stale responses are owed is thrown away
  assign w_drop    = imem_rvalid && (w_redir || (r_discard != {CW{1'b0}}));
  assign w_push    = imem_rvalid && !w_drop;
  assign w_pop     = out_valid && out_ready && !w_redir;

  assign out_valid            = !w_q_empty;
  assign {out_instr, out_pc}  = w_q_data;
  assign done                 = r_done;

  fetch_queue #(
    .WIDTH (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  ({imem_rdata, w_sh_pc}),
    .o_data  (w_q_data),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  // Shadow of issued addresses (+PC_STEP); its occupancy is the in-flight count.
  // Never flushed: stale responses still have to retire their entries.
  fetch_queue #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_pop   (imem_rvalid),
    .i_flush (1'b0),
    .i_data  (w_pc_next),
    .o_data  (w_sh_pc),
    .o_count (w_inflight),
    .o_full  (w_sh_full),
    .o_empty (w_sh_empty)
  );

  // Lifecycle FSM with registered done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (halt) begin
            r_state <= IDLE;
          end else if (start) begin
            r_state <= FETCH;
          end else begin
            r_state <= IDLE;
          end
        end
        FETCH: begin
          if (halt) begin
            r_state <= DRAIN;
          end else begin
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (w_sh_empty && w_q_empty) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Program counter and stale-response discard counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_discard <= {CW{1'b0}};
    end else begin
      if (w_redir) begin
        r_pc <= redirect_pc;
      end else if (w_issue) begin
        r_pc <= w_pc_next;
      end
      if (w_redir) begin
        r_discard <= (imem_rvalid && !w_sh_empty) ? (w_inflight - CW'(1)) : w_inflight;
      end else if (imem_rvalid && (r_discard != {CW{1'b0}})) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [PERF_CNT_W-1:0] r_perf_fetched;
  logic [PERF_CNT_W-1:0] r_perf_flushed;
  logic [PERF_CNT_W-1:0] w_flush_amt;

  assign w_flush_amt = (w_redir ? PERF_CNT_W'(w_q_count) : {PERF_CNT_W{1'b0}})
                     + PERF_CNT_W'(w_drop);
  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;

  // Saturating fetch/flush event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= {PERF_CNT_W{1'b0}};
      r_perf_flushed <= {PERF_CNT_W{1'b0}};
    end else begin
      r_perf_fetched <= sat_add(r_perf_fetched, PERF_CNT_W'(w_push));
      r_perf_flushed <= sat_add(r_perf_flushed, w_flush_amt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple in-order memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        done;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        rsp_en = 1'b1;
  logic [9:0]  pend[$];
  logic [9:0]  iss[$];
  logic [9:0]  rx_pc[$];
  logic [31:0] rx_in[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .done           (done)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [9:0] a);
    return 32'hA000_0000 | {22'd0, a};
  endfunction

  // Log grants, deliveries and done pulses on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (imem_req && imem_gnt) begin
          iss.push_back(imem_addr);
          pend.push_back(imem_addr);
        end
        if (out_valid && out_ready && !redirect_valid) begin
          rx_pc.push_back(out_pc);
          rx_in.push_back(out_instr);
        end
        if (done) done_cnt++;
      end
    end
  end

  // Memory: returns one pending word per cycle, the cycle after its grant at the earliest
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (rst && rsp_en && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_pc.delete();
    rx_in.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 10'd0;
    imem_gnt = 1'b1; out_ready = 1'b1; rsp_en = 1'b1;
    #12;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (imem_addr !== 10'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", imem_addr); end
    tick(1);
    rst = 1'b1;
    tick(2);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    iss.delete(); clear_rx();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin bad++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=000", imem_req, imem_addr); end
    tick(12);
    total++; if (iss.size() < 4 || rx_pc.size() < 3) begin bad++; $display("FAIL stream_sizes: got iss=%0d rx=%0d want >=4 >=3", iss.size(), rx_pc.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (iss[i] !== 10'(4 * i)) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", i, iss[i], 10'(4 * i)); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_pc[i] !== 10'(4 * (i + 1)) || rx_in[i] !== instr_of(10'(4 * i))) begin
        bad++; $display("FAIL stream_out%0d: got pc=%h instr=%h want pc=%h instr=%h", i, rx_pc[i], rx_in[i], 10'(4 * (i + 1)), instr_of(10'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    logic [9:0] base;
    done_cnt = 0;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(20);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_drain_done: got %0d want 1", done_cnt); end
    base = iss[iss.size() - 1] + 10'd4;
    n0 = iss.size();
    out_ready = 1'b0;
    clear_rx();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    total++; if (iss.size() - n0 !== 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", iss.size() - n0); end
    total++; if (iss[n0] !== base) begin bad++; $display("FAIL bp_resume_pc: got %h want %h", iss[n0], base); end
    @(negedge clk);
    total++; if (imem_req !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall: got req=%b valid=%b want req=0 valid=1", imem_req, out_valid); end
    tick(1);
    out_ready = 1'b1;
    tick(12);
    total++; if (rx_pc.size() < 6 || iss.size() - n0 < 6) begin bad++; $display("FAIL bp_resume: got rx=%0d grants=%0d want >=6 >=6", rx_pc.size(), iss.size() - n0); end
    for (int i = 0; i < 6; i++) begin
      total++; if (rx_pc[i] !== base + 10'(4 * (i + 1)) || rx_in[i] !== instr_of(base + 10'(4 * i))) begin
        bad++; $display("FAIL bp_order%0d: got pc=%h instr=%h want pc=%h", i, rx_pc[i], rx_in[i], base + 10'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_redirect();
    int n0;
    imem_gnt = 1'b0;
    tick(4);
    out_ready = 1'b0;
    imem_gnt = 1'b1;
    rsp_en = 1'b1;
    tick(2);
    rsp_en = 1'b0;
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc = 10'h100;
    rsp_en = 1'b1;
    n0 = iss.size();
    clear_rx();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL redir_cycle: got valid=%b req=%b want valid=1 req=0", out_valid, imem_req); end
    tick(1);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed: got valid=%b want 0", out_valid); end
    tick(8);
    total++; if (iss[n0] !== 10'h100) begin bad++; $display("FAIL redir_addr: got %h want 100", iss[n0]); end
    total++; if (rx_pc.size() < 2 || rx_pc[0] !== 10'h104 || rx_in[0] !== 32'hA000_0100 || rx_pc[1] !== 10'h108) begin
      bad++; $display("FAIL redir_out: got n=%0d pc0=%h instr0=%h pc1=%h want pc0=104 instr0=a0000100 pc1=108", rx_pc.size(), rx_pc[0], rx_in[0], rx_pc[1]);
    end
`ifdef FETCH_PERF_EN
    total++; if (perf_flushed < 16'd2) begin bad++; $display("FAIL perf_flushed: got %0d want >=2", perf_flushed); end
`endif
  endtask

  task automatic test_wrap();
    int n0;
    redirect_valid = 1'b1;
    redirect_pc = 10'h3F8;
    tick(1);
    redirect_valid = 1'b0;
    n0 = iss.size();
    clear_rx();
    tick(10);
    total++; if (iss[n0] !== 10'h3F8 || iss[n0+1] !== 10'h3FC || iss[n0+2] !== 10'h000 || iss[n0+3] !== 10'h004) begin
      bad++; $display("FAIL wrap_addr: got %h %h %h %h want 3f8 3fc 000 004", iss[n0], iss[n0+1], iss[n0+2], iss[n0+3]);
    end
    total++; if (rx_pc[0] !== 10'h3FC || rx_pc[1] !== 10'h000 || rx_in[1] !== 32'hA000_03FC || rx_pc[2] !== 10'h004) begin
      bad++; $display("FAIL wrap_out: got pc=%h %h %h instr1=%h want 3fc 000 004 a00003fc", rx_pc[0], rx_pc[1], rx_pc[2], rx_in[1]);
    end
  endtask

  task automatic test_halt_drain();
    int n0;
    out_ready = 1'b0;
    rsp_en = 1'b1;
    tick(8);
    out_ready = 1'b1;
    rsp_en = 1'b0;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    halt = 1'b1;
    rsp_en = 1'b1;
    n0 = iss.size();
    done_cnt = 0;
    clear_rx();
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req: got %b want 0", imem_req); end
    tick(1);
    halt = 1'b0;
    out_ready = 1'b1;
    tick(20);
    total++; if (iss.size() !== n0) begin bad++; $display("FAIL halt_no_issue: got %0d grants want 0", iss.size() - n0); end
    total++; if (rx_pc.size() !== 4) begin bad++; $display("FAIL halt_delivered: got %0d want 4", rx_pc.size()); end
    for (int i = 1; i < 4; i++) begin
      total++; if (rx_pc[i] !== rx_pc[0] + 10'(4 * i)) begin bad++; $display("FAIL halt_order%0d: got %h want %h", i, rx_pc[i], rx_pc[0] + 10'(4 * i)); end
    end
    total++; if (rx_pc[3] !== iss[n0-1] + 10'd4) begin bad++; $display("FAIL halt_last: got %h want %h", rx_pc[3], iss[n0-1] + 10'd4); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL halt_done: got %0d pulses want 1", done_cnt); end
    @(negedge clk);
    total++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL halt_idle: got req=%b valid=%b done=%b want 0 0 0", imem_req, out_valid, done); end
  endtask

  task automatic test_reset_mid();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL restart_req: got %b want 1", imem_req); end
    tick(6);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_stream_valid: got %b want 1", out_valid); end
    @(posedge clk);
    #3;
    rst = 1'b0;
    pend.delete();
    #1;
    total++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_outs: got req=%b valid=%b done=%b want 0 0 0", imem_req, out_valid, done); end
    total++; if (imem_addr !== 10'h000) begin bad++; $display("FAIL mid_reset_addr: got %h want 000", imem_addr); end
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
